// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
// Module   : camera_pkg
// Brief    : Shared types for the camera emulator: pattern codes, counter type,
//            timing FSM state encoding and the colour-bar table.
// Revision : 1.0 - initial release
// ============================================================================
package camera_pkg;

    typedef enum logic [1:0] {
        PAT_GRADIENT = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CONST    = 2'd2,
        PAT_COUNTER  = 2'd3
    } pattern_e;

    typedef logic [10:0] cnt_t;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_vsync  = 3'd1;
    localparam logic [2:0] c_st_vback  = 3'd2;
    localparam logic [2:0] c_st_active = 3'd3;
    localparam logic [2:0] c_st_vfront = 3'd4;

    localparam logic [15:0] c_CONST_WORD = 16'hA5C3;

    // RGB565: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] colour;
        case (idx)
            3'd0:    colour = 16'hFFFF;
            3'd1:    colour = 16'hFFE0;
            3'd2:    colour = 16'h07FF;
            3'd3:    colour = 16'h07E0;
            3'd4:    colour = 16'hF81F;
            3'd5:    colour = 16'hF800;
            3'd6:    colour = 16'h001F;
            default: colour = 16'h0000;
        endcase
        return colour;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov_sensor_emu_if.sv
`default_nettype none
// ============================================================================
// Module   : ov_sensor_emu_if
// Brief    : DVP-style camera bus: host controls plus emulated sensor outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface ov_sensor_emu_if;
    logic       enable;
    logic [1:0] pattern;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;
    logic       frame_done;

    modport master (
        output enable, pattern,
        input  pclk, vsync, href, data, frame_done
    );

    modport slave (
        input  enable, pattern,
        output pclk, vsync, href, data, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/emu_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : emu_pattern_gen
// Brief    : Combinational 16-bit test-pattern pixel from pattern, x, y, frame.
// Revision : 1.0 - initial release
// ============================================================================
module emu_pattern_gen
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  wire logic [1:0] i_pattern,
    input  wire cnt_t       i_x,
    input  wire cnt_t       i_y,
    input  wire logic [7:0] i_frame_cnt,
    output logic [15:0]     o_pixel
);
    logic [13:0] w_bar_num;
    logic [13:0] w_bar_idx;
    logic        w_unused;

    // Bar index = x*8/H_ACTIVE, always 0..7 while x is inside the active line
    assign w_bar_num = {i_x, 3'b000};
    assign w_bar_idx = w_bar_num / 14'(H_ACTIVE);
    assign w_unused  = &{1'b0, i_y[10:8], w_bar_idx[13:3]};

    always_comb begin
        o_pixel = 16'h0000;
        case (pattern_e'(i_pattern))
            PAT_GRADIENT: o_pixel = {i_x[7:0], i_y[7:0]};
            PAT_BARS:     o_pixel = bar_colour(w_bar_idx[2:0]);
            PAT_CONST:    o_pixel = c_CONST_WORD;
            PAT_COUNTER:  o_pixel = {8'h00, i_frame_cnt};
            default:      o_pixel = 16'h0000;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/ov_sensor_emu.sv
`default_nettype none
// ============================================================================
// Module   : ov_sensor_emu
// Brief    : OV-style camera emulator: pclk = clk/2, frame/line timing FSM and
//            byte serialisation of a selectable test pattern.
// Revision : 1.0 - initial release
// ============================================================================
module ov_sensor_emu
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int BPP      = 2
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    ov_sensor_emu_if.slave bus
);
    localparam cnt_t c_H_LAST = cnt_t'(H_ACTIVE + H_BLANK - 1);
    localparam cnt_t c_HA     = cnt_t'(H_ACTIVE);

    logic       r_started;
    logic       r_pclk;
    logic       r_byte;
    logic       r_frame_done;
    logic [2:0] r_state;
    cnt_t       r_hpix;
    cnt_t       r_line;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_frame_cnt_lat;
    logic [1:0] r_pattern_lat;

    logic        w_tick;
    logic        w_byte_last;
    logic        w_pix_last;
    logic        w_line_end;
    logic        w_frame_end;
    logic        w_start;
    logic        w_href;
    cnt_t        w_line_last;
    logic [2:0]  w_next_state;
    logic [15:0] w_pixel;
    logic [7:0]  w_byte;

    always_comb begin
        w_line_last  = cnt_t'(0);
        w_next_state = c_st_idle;
        case (r_state)
            c_st_vsync:  begin w_line_last = cnt_t'(V_SYNC - 1);   w_next_state = c_st_vback;  end
            c_st_vback:  begin w_line_last = cnt_t'(V_BACK - 1);   w_next_state = c_st_active; end
            c_st_active: begin w_line_last = cnt_t'(V_ACTIVE - 1); w_next_state = c_st_vfront; end
            c_st_vfront: begin w_line_last = cnt_t'(V_FRONT - 1);  w_next_state = c_st_idle;   end
            default:     ;
        endcase
    end

    // w_tick marks the clk edge that takes pclk 1->0; all timing moves there
    assign w_tick      = r_started & r_pclk;
    assign w_byte_last = (BPP == 1) ? 1'b1 : r_byte;
    assign w_pix_last  = w_byte_last && (r_hpix == c_H_LAST);
    assign w_line_end  = w_pix_last && (r_line == w_line_last);
    assign w_frame_end = w_tick && (r_state == c_st_vfront) && w_line_end;
    assign w_start     = bus.enable && ((w_tick && (r_state == c_st_idle)) || w_frame_end);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_started       <= 1'b0;
            r_pclk          <= 1'b0;
            r_byte          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_state         <= c_st_idle;
            r_hpix          <= '0;
            r_line          <= '0;
            r_frame_cnt     <= 8'd0;
            r_frame_cnt_lat <= 8'd0;
            r_pattern_lat   <= 2'd0;
        end else begin
            // r_started delays the first pclk rise to the second clk edge
            r_started    <= 1'b1;
            r_pclk       <= r_started & ~r_pclk;
            r_frame_done <= w_frame_end;
            if (w_tick && (r_state != c_st_idle)) begin
                r_byte <= ~w_byte_last;
                if (w_byte_last) r_hpix <= (r_hpix == c_H_LAST) ? '0 : r_hpix + cnt_t'(1);
                if (w_pix_last)  r_line <= w_line_end ? '0 : r_line + cnt_t'(1);
                if (w_line_end)  r_state <= w_next_state;
            end
            if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
            // Back-to-back frames latch the already-incremented frame count
            if (w_start) begin
                r_state         <= c_st_vsync;
                r_pattern_lat   <= bus.pattern;
                r_frame_cnt_lat <= w_frame_end ? r_frame_cnt + 8'd1 : r_frame_cnt;
            end
        end
    end

    emu_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .i_pattern   (r_pattern_lat),
        .i_x         (r_hpix),
        .i_y         (r_line),
        .i_frame_cnt (r_frame_cnt_lat),
        .o_pixel     (w_pixel)
    );

    assign w_href = (r_state == c_st_active) && (r_hpix < c_HA);
    assign w_byte = ((BPP == 2) && !r_byte) ? w_pixel[15:8] : w_pixel[7:0];

    assign bus.pclk       = r_pclk;
    assign bus.vsync      = (r_state == c_st_vsync);
    assign bus.href       = w_href;
    assign bus.data       = w_href ? w_byte : 8'h00;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_ov_sensor_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov_sensor_emu
// Brief    : Self-checking bench for ov_sensor_emu (BPP=2 and BPP=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ov_sensor_emu;
    localparam int HA = 4, HB = 2, VS = 1, VB = 1, VA = 2, VF = 1;
    localparam int LINES = VS + VB + VA + VF;
    localparam logic [15:0] BARS [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ov_sensor_emu_if if2 ();
    ov_sensor_emu_if if1 ();

    ov_sensor_emu #(.H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB),
                    .V_ACTIVE(VA), .V_FRONT(VF), .BPP(2))
        dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    ov_sensor_emu #(.H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB),
                    .V_ACTIVE(VA), .V_FRONT(VF), .BPP(1))
        dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

    always #5 clk = ~clk;

    // Monitors on the BPP=2 instance: frame_done pulses/spacing and vsync starts
    int   cyc = 0, fd_cnt = 0, fd_last = 0, fd_gap = 0, vs_rise = 0;
    logic vs_q = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (if2.frame_done === 1'b1) begin
            fd_cnt  <= fd_cnt + 1;
            fd_gap  <= cyc - fd_last;
            fd_last <= cyc;
        end
        if (if2.vsync === 1'b1 && !vs_q) vs_rise <= vs_rise + 1;
        vs_q <= (if2.vsync === 1'b1);
    end

    // Expected {vsync, href, data} for pclk period p counted from frame start
    function automatic logic [9:0] model(input int bpp, input int pat, input int fcnt, input int p);
        int line_len, line, q, x, y, bi;
        logic vs, hr;
        logic [15:0] w;
        logic [7:0] b;
        line_len = (HA + HB) * bpp;
        line = p / line_len;
        q    = p % line_len;
        vs   = (line < VS);
        hr   = (line >= VS + VB) && (line < VS + VB + VA) && (q < HA * bpp);
        x    = q / bpp;
        y    = line - VS - VB;
        bi   = q % bpp;
        if (pat == 0)      w = {x[7:0], y[7:0]};
        else if (pat == 1) w = BARS[(x * 8 / HA) % 8];
        else if (pat == 2) w = 16'hA5C3;
        else               w = {8'h00, fcnt[7:0]};
        b = (bpp == 2 && bi == 0) ? w[15:8] : w[7:0];
        return {vs, hr, hr ? b : 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next pclk-high half period and sample that instance
    task automatic sample(input bit sel, output logic [9:0] obs);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (((sel ? if1.pclk : if2.pclk) !== 1'b1) && n < 4);
        if (n >= 4) check("pclk_timeout", 32'd0, 32'd1);
        obs = sel ? {if1.vsync, if1.href, if1.data} : {if2.vsync, if2.href, if2.data};
    endtask

    task automatic wait_frame(input bit sel, output logic [9:0] first);
        int n = 0;
        logic [9:0] s;
        do begin
            sample(sel, s);
            n++;
        end while (s[9] !== 1'b1 && n < 400);
        check("frame_start", {31'b0, s[9]}, 32'd1);
        first = s;
    endtask

    task automatic check_frame(input bit sel, input int bpp, input int pat, input int fcnt,
                               input int npat, input bit en_after, input int exp_done,
                               input int exp_gap);
        logic [9:0] s;
        int len, mid;
        len = LINES * (HA + HB) * bpp;
        mid = (VS + VB + 1) * (HA + HB) * bpp + 1;
        wait_frame(sel, s);
        for (int p = 0; p < len; p++) begin
            if (p > 0) sample(sel, s);
            check($sformatf("px sel=%0d pat=%0d f=%0d p=%0d", sel, pat, fcnt, p),
                  {22'b0, s}, {22'b0, model(bpp, pat, fcnt, p)});
            if (p == 2 && exp_done >= 0) check("frame_done_count", fd_cnt, exp_done);
            if (p == 2 && exp_gap > 0)   check("frame_done_period", fd_gap, exp_gap);
            if (p == mid) begin
                if (sel) begin if1.pattern = 2'(npat); if1.enable = en_after; end
                else     begin if2.pattern = 2'(npat); if2.enable = en_after; end
            end
        end
    endtask

    initial begin
        logic [9:0] s;
        int pat, npat, snap;
        if2.enable = 1'b0; if2.pattern = 2'd0;
        if1.enable = 1'b0; if1.pattern = 2'd0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out2", {if2.pclk, if2.vsync, if2.href, if2.data, if2.frame_done}, 32'd0);
        check("rst_out1", {if1.pclk, if1.vsync, if1.href, if1.data, if1.frame_done}, 32'd0);

        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #2; check("pclk_edge1_low", if2.pclk, 32'd0);
        @(posedge clk); #2; check("pclk_edge2_high", if2.pclk, 32'd1);
        @(posedge clk); #2; check("pclk_toggle", if2.pclk, 32'd0);
        repeat (20) @(posedge clk);
        #2;
        check("idle_outputs", {if2.vsync, if2.href, if2.data, if2.frame_done}, 32'd0);
        check("idle_no_vsync", vs_rise, 32'd0);

        // Back-to-back frames; next frame's pattern is changed mid-frame
        pat = 0;
        if2.pattern = 2'd0;
        if2.enable  = 1'b1;
        for (int k = 0; k < 258; k++) begin
            if (k == 0)       npat = 3;
            else if (k == 1)  npat = 1;
            else if (k < 254) npat = int'($urandom_range(0, 3));
            else              npat = 3;
            check_frame(1'b0, 2, pat, k % 256, npat, (k == 257) ? 1'b0 : 1'b1,
                        (k > 0) ? k : -1, (k > 1) ? 120 : 0);
            pat = npat;
        end

        // Enable was dropped mid-ACTIVE of the last frame
        repeat (10) @(posedge clk);
        #2;
        check("done_after_drop", fd_cnt, 32'd258);
        snap = vs_rise;
        repeat (300) @(posedge clk);
        #2;
        check("no_vsync_after_drop", vs_rise, snap);
        check("idle_after_drop", {if2.vsync, if2.href, if2.data, if2.frame_done}, 32'd0);

        // Reset in the middle of an active line
        if2.pattern = 2'd3;
        if2.enable  = 1'b1;
        wait_frame(1'b0, s);
        for (int i = 0; i < 29; i++) sample(1'b0, s);
        check("pre_reset_px", {22'b0, s}, {22'b0, model(2, 3, 2, 29)});
        #1 reset_n = 1'b0;
        #1;
        check("reset_async_out2", {if2.pclk, if2.vsync, if2.href, if2.data, if2.frame_done}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        check_frame(1'b0, 2, 3, 0, 3, 1'b1, -1, 0);
        if2.enable = 1'b0;

        // BPP=1 instance, constant pattern
        if1.pattern = 2'd2;
        if1.enable  = 1'b1;
        check_frame(1'b1, 1, 2, 0, 2, 1'b1, -1, 0);
        check_frame(1'b1, 1, 2, 1, 2, 1'b0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/ov_sensor_emu.md
OV_SENSOR_EMU -- requirements
Module: ov_sensor_emu

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter H_BLANK, default 144: blank pixel periods per line (href low).
REQ-003 Parameter V_SYNC, default 3: lines with vsync high.
REQ-004 Parameter V_BACK, default 17: blank lines after vsync, before first active line.
REQ-005 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-006 Parameter V_FRONT, default 10: blank lines after last active line.
REQ-007 Parameter BPP, default 2, legal 1 or 2: bytes per pixel on the bus.
REQ-008 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-009 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-010 Port enable, input, 1: permits a new frame to start.
REQ-011 Port pattern, input, 2: 0 gradient, 1 colour bars, 2 constant, 3 frame counter.
REQ-012 Port pclk, output, 1: emulated sensor pixel clock, clk/2.
REQ-013 Port vsync, output, 1: frame sync, high during V_SYNC lines.
REQ-014 Port href, output, 1: high while active bytes of an active line are driven.
REQ-015 Port data, output, 8: pixel byte, valid on pclk rising edge while href high.
REQ-016 Port frame_done, output, 1: one-clk pulse after the last V_FRONT line.

Function
REQ-017 pclk SHALL toggle every clk cycle once out of reset; vsync, href, data SHALL change only on the clk edge that drives pclk 1->0.
REQ-018 One "pclk period" = 2 clk; one pixel period = BPP pclk periods; one line = (H_ACTIVE+H_BLANK) pixel periods.
REQ-019 FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT; line/pixel/byte counters advance only on pclk falling edges.
REQ-020 IDLE -> VSYNC when enable=1 at a pclk falling edge; otherwise remain IDLE with vsync=href=0, data=0.
REQ-021 VSYNC lasts V_SYNC full lines, VBACK V_BACK lines, ACTIVE V_ACTIVE lines, VFRONT V_FRONT lines, each then advancing in that order.
REQ-022 In ACTIVE, href=1 for exactly H_ACTIVE*BPP consecutive pclk periods at line start, then 0 for H_BLANK*BPP periods; href=0 in all other states.
REQ-023 pattern and frame counter SHALL be sampled at VSYNC entry and held for the whole frame.
REQ-024 Pixel word (16 bit): gradient = {x[7:0], y[7:0]}; bars = 8 equal-width bars of fixed RGB565 colours indexed by x*8/H_ACTIVE; constant = 16'hA5C3; counter = {8'h00, frame_cnt}.
REQ-025 BPP=2: high byte first, then low byte; BPP=1: low byte only.
REQ-026 data SHALL be 0 whenever href=0.
REQ-027 After VFRONT: frame_done=1 for one clk, frame_cnt (8 bit) increments with wrap 255->0, then VSYNC if enable=1 else IDLE, no gap pclk periods.
REQ-028 enable deasserted mid-frame SHALL NOT abort the frame; it only gates the next frame start.
REQ-029 x counts 0..H_ACTIVE-1 and y 0..V_ACTIVE-1 within active region; counters wide enough for parameters (11 bit).

Reset
REQ-030 reset_n low SHALL immediately force pclk=0, vsync=0, href=0, data=0, frame_done=0, FSM=IDLE, all counters and frame_cnt=0, including mid-frame.
REQ-031 First pclk rising edge SHALL occur on the second clk edge after reset_n release.

Structure
REQ-032 Pattern encodings, bar colour table and FSM state encoding SHALL live in a shared package camera_pkg.
REQ-033 Pixel-word generation SHALL be a sub-module emu_pattern_gen (combinational from pattern, x, y, frame_cnt); timing FSM in ov_sensor_emu.

Verification
REQ-034 Params H_ACTIVE=4,H_BLANK=2,V_SYNC=1,V_BACK=1,V_ACTIVE=2,V_FRONT=1,BPP=2, enable=1 -> vsync high 12 pclk periods, href high 8 periods per active line, frame_done every 60 pclk periods.
REQ-035 Same params, pattern=0 -> line y=1 bytes 00,01,01,01,02,01,03,01.
REQ-036 pattern=2, BPP=1 -> every href byte = C3, data=0 outside href.
REQ-037 pattern=3, 257 frames -> frame 256 reports counter byte 00 (wrap), frame 1 reports 01.
REQ-038 enable dropped mid-ACTIVE -> frame completes, frame_done pulses, FSM returns IDLE, no further vsync.
REQ-039 reset_n asserted mid-ACTIVE -> outputs zero same cycle; after release and enable=1, fresh frame with frame_cnt=0.
